full_adder_1bit: RTL and testbench
==================================

Name: full_adder_1bit

Overview:
- Single-bit full adder, the leaf cell of the ripple-carry adder chain.
- Combinational sum/carry path keeps the positional (a, b, cin, sum, cout) contract used by the 4-bit ripple adder.
- Adds a clocked output pipeline and a bit-serial carry-feedback mode, so the same cell can also be used as a registered slice or as an LSB-first serial adder.

Parameters:
- LATENCY, 1, depth of the registered output pipeline in clock cycles; legal range 1..4; elaboration error outside the range.
- SER_CARRY_INIT, 0, value loaded into the serial carry register at reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  addend bit.
- b  input  1  addend bit.
- cin  input  1  carry in.
- sum  output  1  combinational sum.
- cout  output  1  combinational carry out.
- en  input  1  pipeline advance enable.
- ser_en  input  1  selects bit-serial mode for the registered path.
- ser_start  input  1  first (LSB) bit of a serial word; valid with ser_en.
- sum_q  output  1  registered sum, LATENCY cycles after capture.
- cout_q  output  1  registered carry out.
- valid_q  output  1  registered sample valid.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Combinational path, always active and independent of clk, rst_n and en:
  - sum = a XOR b XOR cin.
  - cout = (a AND b) OR (a AND cin) OR (b AND cin).
- Effective carry-in (ci_eff) for the registered path:
  - ser_en=0: ci_eff = cin.
  - ser_en=1 and ser_start=1: ci_eff = cin.
  - ser_en=1 and ser_start=0: ci_eff = carry_r, the internal serial carry register.
- s_eff and c_eff are the full-adder outputs of (a, b, ci_eff).
- Pipeline: LATENCY stages, each holding {s, c, v}.
  - Stage 1 captures {s_eff, c_eff, en} on every clock.
  - Stage k+1 captures stage k on every clock.
  - sum_q/cout_q/valid_q are the last stage, so a sample is visible exactly LATENCY rising edges after capture.
  - With en=0 a bubble propagates (v=0) and the s/c data bits hold their previous values.
- Serial carry register carry_r: updates to c_eff on each rising edge with en=1 and ser_en=1; holds otherwise.
- Reset (rst_n=0, asynchronous, any time, including mid-word):
  - All pipeline s/c/v bits go to 0; sum_q=0, cout_q=0, valid_q=0.
  - carry_r = SER_CARRY_INIT.
  - Combinational sum/cout remain live.
- Reset release: the first capture happens at the first rising edge with rst_n=1.
- Simultaneous ser_start and a carry update: ser_start wins; the carry chain restarts from cin.
- ser_en toggled mid-word: carry_r holds while ser_en=0, and a later ser_en=1 without ser_start resumes from the held carry.
- No X propagation from unused inputs: ser_start is ignored when ser_en=0.

Optional Feature:
- Macro FA_SERIAL_EN.
- Defined: carry_r and the serial carry-in mux exist, as described above.
- Undefined:
  - carry_r is removed.
  - ser_en and ser_start remain as ports but are ignored.
  - ci_eff = cin always.
  - The registered path is a pure pipelined copy of the combinational adder.

Test Plan:
- Exhaustive combinational check: all 8 (a,b,cin) combos match the truth table.
  - (1,1,1) -> sum=1, cout=1.
  - (1,0,0) -> sum=1, cout=0.
  - (0,1,1) -> sum=0, cout=1.
  - (0,0,0) -> sum=0, cout=0.
- Latency, LATENCY=1 then LATENCY=3:
  - Drive a=1, b=1, cin=0, en=1 for one edge, then en=0.
  - Required: sum_q=0, cout_q=1, valid_q=1 exactly 1 (resp. 3) edges later, valid_q=0 on the following edge.
- Serial add 5+3 LSB-first (FA_SERIAL_EN defined, ser_en=1, en=1):
  - a bits 1,0,1,0; b bits 1,1,0,0; cin=0 with ser_start on the first bit.
  - Required: sum_q sequence 0,0,0,1 and final cout_q=0, i.e. 8.
- Serial add 2+3 with cin=1: bits a=0,1,0,0; b=1,1,0,0 -> sum_q 0,1,1,0, i.e. 6.
- Asynchronous reset mid-serial-word:
  - Assert rst_n=0 between edges.
  - Required: sum_q, cout_q and valid_q go to 0 immediately; carry_r=SER_CARRY_INIT.
  - A new word with ser_start yields the correct result.
- FA_SERIAL_EN undefined:
  - Repeat the 5+3 serial stimulus without ser_start on later bits.
  - Required: each output equals the plain full adder of (a, b, cin), e.g. bit1 (0,1,0) -> sum_q=1, cout_q=0.

Source files
------------

// File: rtl/full_adder_1bit.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
//
// Single-bit full adder: the leaf cell of the ripple-carry adder chain.
//
// The cell has two views of the same addition:
//   * A combinational path (sum, cout) that is always live. It is independent
//     of clk, rst_n and en, and it keeps the positional (a, b, cin, sum, cout)
//     contract that the 4-bit ripple adder depends on.
//   * A registered path (sum_q, cout_q, valid_q) that is LATENCY stages deep.
//     With the serial option compiled in, it can also run as an LSB-first
//     bit-serial adder that feeds its carry back through an internal register.
//
// Build option:
//   FA_SERIAL_EN  When defined, the serial carry register and the carry-in mux
//                 are built. When undefined, ser_en and ser_start are ignored
//                 and the registered path is a plain pipelined copy of the
//                 combinational adder.
//
// Parameters:
//   LATENCY         Depth of the registered pipeline, 1..4 cycles.
//   SER_CARRY_INIT  Value the serial carry register takes at reset.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   a, b       in   addend bits
//   cin        in   carry in
//   sum        out  combinational sum
//   cout       out  combinational carry out
//   en         in   pipeline advance enable; en=0 inserts a bubble
//   ser_en     in   selects bit-serial mode for the registered path
//   ser_start  in   marks the first (LSB) bit of a serial word; only
//                   looked at when ser_en=1
//   sum_q      out  registered sum, LATENCY edges after capture
//   cout_q     out  registered carry out
//   valid_q    out  registered sample valid
// -----------------------------------------------------------------------------
module full_adder_1bit #(
  parameter int   LATENCY        = 1,
  parameter logic SER_CARRY_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
  input  logic en,
  input  logic ser_en,
  input  logic ser_start,
  output logic sum_q,
  output logic cout_q,
  output logic valid_q
);

  // A pipeline depth outside 1..4 is a configuration error, so stop it at
  // elaboration time rather than build something odd.
  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("full_adder_1bit: LATENCY must be in 1..4");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Combinational full adder: always live, even while reset is held.
  // ---------------------------------------------------------------------------
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

  // ---------------------------------------------------------------------------
  // Adder that feeds the registered path. Its carry-in is either cin or the
  // fed-back serial carry.
  // ---------------------------------------------------------------------------
  logic ci_eff;
  logic s_eff;
  logic c_eff;

  assign s_eff = a ^ b ^ ci_eff;
  assign c_eff = (a & b) | (a & ci_eff) | (b & ci_eff);

`ifdef FA_SERIAL_EN
  logic carry_r;

  // Take cin when the cell is not in serial mode or when a new word starts.
  // Otherwise continue the word from the carry held in carry_r. ser_start has
  // no effect unless ser_en=1, so an undriven ser_start cannot leak into the
  // sum while the cell is used as a plain slice.
  // NOTE: assign the default first so that every path through the block
  // writes ci_eff; without it, synthesis infers a latch.
  always_comb begin
    ci_eff = cin;
    if (ser_en && !ser_start) begin
      ci_eff = carry_r;
    end
  end

  // The carry advances only on enabled serial beats. A beat that also carries
  // ser_start stores the carry-out of the fresh bit (built from cin), so a new
  // word overrides the carry left over from the last one. While ser_en=0 the
  // register holds, so a word interrupted by non-serial traffic continues from
  // the same carry once ser_en returns.
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples pre-edge values, no matter how the blocks are ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r <= SER_CARRY_INIT;
    end else if (en && ser_en) begin
      carry_r <= c_eff;
    end
  end

  logic unused_ser_cfg;
  assign unused_ser_cfg = 1'b0;
`else
  // Without the serial option, the registered path is a delayed copy of the
  // combinational adder. The serial controls stay on the port list so that
  // both builds can be swapped in the same place.
  assign ci_eff = cin;

  logic unused_ser_cfg;
  assign unused_ser_cfg = &{1'b0, ser_en, ser_start, SER_CARRY_INIT};
`endif

  // ---------------------------------------------------------------------------
  // Output pipeline. Stage 0 captures the adder result on every edge. Each
  // later stage copies the stage before it, and the last stage drives the
  // outputs, so a sample shows up exactly LATENCY edges after capture.
  //
  // en=0 loads a bubble (v=0) into stage 0, and the data bits of stage 0 keep
  // their old value. Downstream logic that ignores valid then sees steady
  // data instead of adder noise.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] s_pipe;
  logic [LATENCY-1:0] c_pipe;
  logic [LATENCY-1:0] v_pipe;

  // NOTE: the pipeline is only a few flops, not a memory, so every stage is
  // reset. That makes sum_q, cout_q and valid_q drop to 0 the moment rst_n
  // falls, in the middle of a serial word as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_pipe <= '0;
      c_pipe <= '0;
      v_pipe <= '0;
    end else begin
      v_pipe[0] <= en;
      if (en) begin
        s_pipe[0] <= s_eff;
        c_pipe[0] <= c_eff;
      end
      for (int k = 1; k < LATENCY; k++) begin
        s_pipe[k] <= s_pipe[k-1];
        c_pipe[k] <= c_pipe[k-1];
        v_pipe[k] <= v_pipe[k-1];
      end
    end
  end

  assign sum_q   = s_pipe[LATENCY-1];
  assign cout_q  = c_pipe[LATENCY-1];
  assign valid_q = v_pipe[LATENCY-1];

endmodule

// File: tb/tb_full_adder_1bit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_1bit
//
// Drives two instances of full_adder_1bit from the same inputs, one built with
// LATENCY=1 and one with LATENCY=3. A behavioural model keeps, for every clock
// edge since reset, the {sum, cout, valid} value that edge captured, worked
// out with integer arithmetic. The expected registered output of a DUT of
// latency L is the entry captured L edges ago.
//
// A compare process checks both DUTs against the model on every cycle. Directed
// sequences with hand-worked literal values pin down the model itself.
// -----------------------------------------------------------------------------
module tb_full_adder_1bit;

  localparam logic CARRY_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, cin, en, ser_en, ser_start;

  logic sum1, cout1, sum_q1, cout_q1, valid_q1;
  logic sum3, cout3, sum_q3, cout_q3, valid_q3;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  full_adder_1bit #(.LATENCY(1), .SER_CARRY_INIT(CARRY_INIT)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum1), .cout(cout1), .en(en), .ser_en(ser_en), .ser_start(ser_start),
    .sum_q(sum_q1), .cout_q(cout_q1), .valid_q(valid_q1)
  );

  full_adder_1bit #(.LATENCY(3), .SER_CARRY_INIT(CARRY_INIT)) dut3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum3), .cout(cout3), .en(en), .ser_en(ser_en), .ser_start(ser_start),
    .sum_q(sum_q3), .cout_q(cout_q3), .valid_q(valid_q3)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [2:0] hist[$];   // {s, c, v} captured at each edge, oldest first
  logic       m_carry;
  logic       m_s, m_c;  // data last captured while en=1

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_carry = CARRY_INIT;
      m_s = 1'b0;
      m_c = 1'b0;
    end else begin
      int ci;
      int t;
`ifdef FA_SERIAL_EN
      ci = (ser_en && !ser_start) ? int'(m_carry) : int'(cin);
`else
      ci = int'(cin);
`endif
      t = int'(a) + int'(b) + ci;
      if (en) begin
        m_s = (t % 2) == 1;
        m_c = t >= 2;
`ifdef FA_SERIAL_EN
        if (ser_en) m_carry = t >= 2;
`endif
      end
      hist.push_back({m_s, m_c, en});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  function automatic logic [2:0] exp_out(int lat);
    if (hist.size() >= lat) return hist[hist.size() - lat];
    return 3'b000;
  endfunction

  // Compare process: runs on every cycle once it has been armed.
  always begin
    @(posedge clk);
    #2;
    if (run_cmp) begin
      int t;
      t = int'(a) + int'(b) + int'(cin);
      check("comb", {2'b00, sum1, cout1}, {2'b00, (t % 2) == 1, t >= 2});
      check("pipe_l1", {1'b0, sum_q1, cout_q1, valid_q1}, {1'b0, exp_out(1)});
      check("pipe_l3", {1'b0, sum_q3, cout_q3, valid_q3}, {1'b0, exp_out(3)});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0; ser_en = 1'b0; ser_start = 1'b0;
    end
  endtask

  // Feed a 4-bit serial word LSB-first and check each registered bit of the
  // LATENCY=1 instance one edge after it was captured.
  task automatic serial_word(input string name, input logic [3:0] av, input logic [3:0] bv,
                             input logic c0, input logic [3:0] exp_s, input logic [3:0] exp_c);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = av[i]; b = bv[i]; cin = (i == 0) ? c0 : 1'b0;
      en = 1'b1; ser_en = 1'b1; ser_start = (i == 0);
      @(posedge clk);
      #2;
      check(name, {1'b0, sum_q1, cout_q1, valid_q1}, {1'b0, exp_s[i], exp_c[i], 1'b1});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] e58_s, e58_c, e23_s, e23_c;
    logic       post_s, post_c;
`ifdef FA_SERIAL_EN
    e58_s = 4'b1000; e58_c = 4'b0111;   // 5+3 = 8
    e23_s = 4'b0110; e23_c = 4'b0011;   // 2+3+1 = 6
    post_s = 1'b1;   post_c = 1'b0;     // carry restarts at 0: 1+0+0
`else
    e58_s = 4'b0110; e58_c = 4'b0001;   // plain per-bit adds, cin=0
    e23_s = 4'b0000; e23_c = 4'b0011;
    post_s = 1'b0;   post_c = 1'b1;     // plain 1+0+1
`endif

    rst_n = 1'b0;
    a = 0; b = 0; cin = 0; en = 0; ser_en = 0; ser_start = 0;
    #1;
    check("reset_l1", {1'b0, sum_q1, cout_q1, valid_q1}, 4'b0000);
    check("reset_l3", {1'b0, sum_q3, cout_q3, valid_q3}, 4'b0000);

    // Exhaustive combinational truth table, computed while reset is held.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int t;
      v = i[2:0];
      {a, b, cin} = v;
      t = int'(v[2]) + int'(v[1]) + int'(v[0]);
      #1;
      check("comb_tt", {2'b00, sum1, cout1}, {2'b00, (t % 2) == 1, t >= 2});
    end
    {a, b, cin} = 3'b111; #1; check("comb_111", {2'b00, sum1, cout1}, 4'b0011);
    {a, b, cin} = 3'b100; #1; check("comb_100", {2'b00, sum1, cout1}, 4'b0010);
    {a, b, cin} = 3'b011; #1; check("comb_011", {2'b00, sum1, cout1}, 4'b0001);
    {a, b, cin} = 3'b000; #1; check("comb_000", {2'b00, sum1, cout1}, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    run_cmp = 1'b1;
    idle(4);

    // Latency: one enabled sample of 1+1+0 (expect sum=0, cout=1), then
    // bubbles behind it.
    @(negedge clk);
    a = 1; b = 1; cin = 0; en = 1; ser_en = 0; ser_start = 0;
    @(posedge clk); #2;
    check("lat1_hit", {1'b0, sum_q1, cout_q1, valid_q1}, 4'b0011);
    check("lat3_e1", {3'b000, valid_q3}, 4'b0000);
    @(negedge clk); en = 0;
    @(posedge clk); #2;
    check("lat1_after", {3'b000, valid_q1}, 4'b0000);
    check("lat3_e2", {3'b000, valid_q3}, 4'b0000);
    @(posedge clk); #2;
    check("lat3_hit", {1'b0, sum_q3, cout_q3, valid_q3}, 4'b0011);
    @(posedge clk); #2;
    check("lat3_after", {3'b000, valid_q3}, 4'b0000);

    // Serial words, LSB first.
    serial_word("ser_5p3", 4'b0101, 4'b0011, 1'b0, e58_s, e58_c);
    idle(2);
    serial_word("ser_2p3c1", 4'b0010, 4'b0011, 1'b1, e23_s, e23_c);
    idle(2);

    // Asynchronous reset in the middle of a word: two bits of 5+3 leave the
    // serial carry at 1, then reset is asserted between edges.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = (i == 0); b = 1'b1; cin = 1'b0; en = 1; ser_en = 1; ser_start = (i == 0);
    end
    @(negedge clk);
    en = 0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_l1", {1'b0, sum_q1, cout_q1, valid_q1}, 4'b0000);
    check("async_rst_l3", {1'b0, sum_q3, cout_q3, valid_q3}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    // A serial continuation bit with no ser_start reads the carry as it was
    // left by reset.
    a = 1; b = 0; cin = 1; en = 1; ser_en = 1; ser_start = 0;
    @(posedge clk); #2;
    check("post_rst_carry", {1'b0, sum_q1, cout_q1, valid_q1}, {1'b0, post_s, post_c, 1'b1});
    serial_word("ser_after_rst", 4'b0010, 4'b0011, 1'b1, e23_s, e23_c);
    idle(2);

    // Random traffic, with reset pulses now and then between edges.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
      en = ($urandom_range(0, 3) != 0);
      ser_en = ($urandom_range(0, 3) != 0);
      ser_start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rnd_rst_l1", {1'b0, sum_q1, cout_q1, valid_q1}, 4'b0000);
        check("rnd_rst_l3", {1'b0, sum_q3, cout_q3, valid_q3}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    idle(4);

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
